// File: rtl/aes_pkg.sv
// Shared AES constants and sequencer state encoding used by the round
// sequencers and the round-key selector.
package aes_pkg;

  localparam int unsigned AES_WIDTH = 128;
  localparam int unsigned AES_NR    = 10;
  localparam int unsigned AES_RND_W = 4;

  typedef enum logic [2:0] {
    SEQ_IDLE,
    SEQ_INIT,
    SEQ_ISSUE,
    SEQ_WAIT,
    SEQ_DONE
  } seq_state_e;

endpackage

// File: rtl/aes_rkey_sel.sv
// Combinational 11:1 round-key selector indexed by the round counter.
// Out-of-range selects fall back to key 0.
module aes_rkey_sel
  import aes_pkg::*;
#(
  parameter int unsigned WIDTH = AES_WIDTH
) (
  input  logic [AES_RND_W-1:0]        sel,
  input  logic [AES_NR:0][WIDTH-1:0]  keys,
  output logic [WIDTH-1:0]            key_c
);

  always_comb begin
    key_c = keys[0];
    for (int i = 0; i <= int'(AES_NR); i++) begin
      if (sel == AES_RND_W'(i)) key_c = keys[i];
    end
  end

endmodule

// File: rtl/aes_inv_round_sequencer.sv
// AES-128 decryption round sequencer: initial AddRoundKey with K10, then ten
// request/response transactions with an external inverse-round unit (K9..K0).
module aes_inv_round_sequencer
  import aes_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [AES_WIDTH-1:0] data_i,
  input  logic [AES_WIDTH-1:0] key_0_i,
  input  logic [AES_WIDTH-1:0] key_1_i,
  input  logic [AES_WIDTH-1:0] key_2_i,
  input  logic [AES_WIDTH-1:0] key_3_i,
  input  logic [AES_WIDTH-1:0] key_4_i,
  input  logic [AES_WIDTH-1:0] key_5_i,
  input  logic [AES_WIDTH-1:0] key_6_i,
  input  logic [AES_WIDTH-1:0] key_7_i,
  input  logic [AES_WIDTH-1:0] key_8_i,
  input  logic [AES_WIDTH-1:0] key_9_i,
  input  logic [AES_WIDTH-1:0] key_10_i,
  output logic [AES_WIDTH-1:0] rnd_data_o,
  output logic [AES_WIDTH-1:0] rnd_key_o,
  output logic                 rnd_valid_o,
  output logic                 rnd_last_o,
  input  logic [AES_WIDTH-1:0] rnd_data_i,
  input  logic                 rnd_valid_i,
  output logic [AES_WIDTH-1:0] data_o,
  output logic                 data_valid_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 proto_err_o
);

  localparam int unsigned WIDTH = AES_WIDTH;
  localparam int unsigned RW    = AES_RND_W;

  seq_state_e       fsm_q, fsm_d;
  logic [RW-1:0]    round_q, round_d;
  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] data_d;
  logic             data_valid_d;
  logic             proto_err_d;

  logic [AES_NR:0][WIDTH-1:0] keys;

  assign keys = {key_10_i, key_9_i, key_8_i, key_7_i, key_6_i, key_5_i,
                 key_4_i, key_3_i, key_2_i, key_1_i, key_0_i};

  aes_rkey_sel #(.WIDTH(WIDTH)) u_rkey_sel (
    .sel   (round_q),
    .keys  (keys),
    .key_c (rnd_key_o)
  );

  assign rnd_data_o = state_q;

  // FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) fsm_q <= SEQ_IDLE;
    else       fsm_q <= fsm_d;
  end

  // Next-state and datapath updates; a response is legal only while waiting
  always_comb begin
    fsm_d        = fsm_q;
    round_d      = round_q;
    state_d      = state_q;
    data_d       = data_o;
    data_valid_d = data_valid_o;
    proto_err_d  = proto_err_o | (rnd_valid_i && (fsm_q != SEQ_WAIT));

    case (fsm_q)
      SEQ_IDLE: begin
        if (start_i) begin
          fsm_d        = SEQ_INIT;
          data_valid_d = 1'b0;
        end
      end
      SEQ_INIT: begin
        state_d = data_i ^ key_10_i;
        round_d = RW'(AES_NR - 1);
        fsm_d   = SEQ_ISSUE;
      end
      SEQ_ISSUE: begin
        fsm_d = SEQ_WAIT;
      end
      SEQ_WAIT: begin
        if (rnd_valid_i) begin
          state_d = rnd_data_i;
          if (round_q == '0) begin
            fsm_d = SEQ_DONE;
          end else begin
            round_d = round_q - RW'(1);
            fsm_d   = SEQ_ISSUE;
          end
        end
      end
      SEQ_DONE: begin
        data_d       = state_q;
        data_valid_d = 1'b1;
        fsm_d        = SEQ_IDLE;
      end
      default: begin
        fsm_d = SEQ_IDLE;
      end
    endcase
  end

  // Status strobes are registered from the next state so they align with it
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      round_q      <= '0;
      state_q      <= '0;
      data_o       <= '0;
      data_valid_o <= 1'b0;
      proto_err_o  <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      rnd_valid_o  <= 1'b0;
      rnd_last_o   <= 1'b0;
    end else begin
      round_q      <= round_d;
      state_q      <= state_d;
      data_o       <= data_d;
      data_valid_o <= data_valid_d;
      proto_err_o  <= proto_err_d;
      busy_o       <= (fsm_d != SEQ_IDLE);
      done_o       <= (fsm_d == SEQ_DONE);
      rnd_valid_o  <= (fsm_d == SEQ_ISSUE);
      rnd_last_o   <= (fsm_d == SEQ_ISSUE) && (round_d == '0);
    end
  end

endmodule

// File: tb/tb_aes_inv_round_sequencer.sv
// Testbench for aes_inv_round_sequencer: behavioural AES model, inverse-round
// responder with configurable latency, and directed/randomized scenarios.
module tb_aes_inv_round_sequencer;

  logic         clk;
  logic         rst_i;
  logic         start_i;
  logic [127:0] data_i;
  logic [127:0] rk [11];
  logic [127:0] rnd_data_o, rnd_key_o, rnd_data_i, data_o;
  logic         rnd_valid_o, rnd_last_o, rnd_valid_i;
  logic         data_valid_o, busy_o, done_o, proto_err_o;
  logic         resp_valid, inj_valid;

  assign rnd_valid_i = resp_valid | inj_valid;

  aes_inv_round_sequencer dut (
    .clk_i (clk), .rst_i (rst_i), .start_i (start_i), .data_i (data_i),
    .key_0_i (rk[0]), .key_1_i (rk[1]), .key_2_i (rk[2]), .key_3_i (rk[3]),
    .key_4_i (rk[4]), .key_5_i (rk[5]), .key_6_i (rk[6]), .key_7_i (rk[7]),
    .key_8_i (rk[8]), .key_9_i (rk[9]), .key_10_i (rk[10]),
    .rnd_data_o (rnd_data_o), .rnd_key_o (rnd_key_o), .rnd_valid_o (rnd_valid_o),
    .rnd_last_o (rnd_last_o), .rnd_data_i (rnd_data_i), .rnd_valid_i (rnd_valid_i),
    .data_o (data_o), .data_valid_o (data_valid_o), .busy_o (busy_o),
    .done_o (done_o), .proto_err_o (proto_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc;
  int done_cnt;
  int done_cyc;
  int issue_cnt;
  int issue_base;
  int lat_fixed;
  int n_chk;
  int n_pass;
  int ridx;
  int resp_lat;
  logic [127:0] resp_data;
  logic [7:0] sbox  [256];
  logic [7:0] isbox [256];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done_o) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  // ---------------- behavioural AES model ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
          ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox[x] = s;
      isbox[s] = 8'(x);
    end
  endtask

  // Byte i of a block sits at bits [127-8i -: 8]; state[r][c] is byte r+4c.
  function automatic logic [127:0] sub_shift(input logic [127:0] x, input bit inv);
    logic [7:0] b [16];
    logic [127:0] y;
    for (int i = 0; i < 16; i++) b[i] = x[127-8*i -: 8];
    y = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!inv) y[127-8*(r+4*c) -: 8] = sbox[b[r+4*((c+r)%4)]];
        else      y[127-8*(r+4*c) -: 8] = isbox[b[r+4*((c+4-r)%4)]];
    return y;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] x, input bit inv);
    logic [7:0] co [4];
    logic [7:0] a [4];
    logic [7:0] o;
    logic [127:0] y;
    if (!inv) begin co[0] = 8'h02; co[1] = 8'h03; co[2] = 8'h01; co[3] = 8'h01; end
    else      begin co[0] = 8'h0e; co[1] = 8'h0b; co[2] = 8'h0d; co[3] = 8'h09; end
    y = '0;
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) a[j] = x[127-8*(4*c+j) -: 8];
      for (int r = 0; r < 4; r++) begin
        o = 8'h00;
        for (int j = 0; j < 4; j++) o = o ^ gm(co[(j-r+4)%4], a[j]);
        y[127-8*(4*c+r) -: 8] = o;
      end
    end
    return y;
  endfunction

  function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k,
                                             input bit last);
    logic [127:0] t;
    t = sub_shift(s, 1'b1) ^ k;
    if (!last) t = mix(t, 1'b1);
    return t;
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] pt);
    logic [127:0] s;
    s = pt ^ rk[0];
    for (int r = 1; r < 10; r++) s = mix(sub_shift(s, 1'b0), 1'b0) ^ rk[r];
    return sub_shift(s, 1'b0) ^ rk[10];
  endfunction

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int k = 0; k < 11; k++) rk[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- inverse-round responder ----------------
  initial begin
    resp_valid = 1'b0;
    rnd_data_i = '0;
    forever begin
      @(negedge clk);
      if (rnd_valid_o && !rst_i) begin
        ridx = (issue_cnt - issue_base) % 10;
        check_eq("rnd_key_order", rnd_key_o, rk[9-ridx]);
        check_eq("rnd_last", 128'(rnd_last_o), 128'(ridx == 9));
        issue_cnt++;
        resp_data = inv_round(rnd_data_o, rnd_key_o, rnd_last_o);
        resp_lat = (lat_fixed == 0) ? int'($urandom_range(1, 8)) : lat_fixed;
        repeat (resp_lat) @(posedge clk);
        #1;
        rnd_data_i = resp_data;
        resp_valid = 1'b1;
        @(posedge clk);
        #1;
        resp_valid = 1'b0;
      end
    end
  end

  // mode: 0 plain, 1 start pulses while busy, 2 stray response in first ISSUE
  task automatic run_block(input logic [127:0] ct, input logic [127:0] pt,
                           input int lat, input int mode);
    int c0, d0;
    lat_fixed = lat;
    data_i = ct;
    issue_base = issue_cnt;
    d0 = done_cnt;
    start_i = 1'b1;
    c0 = cyc;
    @(posedge clk); #1;
    start_i = 1'b0;
    while (done_cnt == d0 && cyc < c0 + 400) begin
      start_i   = (mode == 1) && (cyc == c0 + 5 || cyc == c0 + 15);
      inj_valid = (mode == 2) && (cyc == c0 + 2);
      @(posedge clk); #1;
    end
    start_i = 1'b0;
    inj_valid = 1'b0;
    check_eq("done_timeout", 128'(done_cnt == d0), 128'(0));
    if (lat > 0) check_eq("done_cycle", 128'(done_cyc), 128'(c0 + 12 + 10*lat));
    check_eq("plaintext", data_o, pt);
    check_eq("data_valid", 128'(data_valid_o), 128'(1));
    check_eq("issue_count", 128'(issue_cnt - issue_base), 128'(10));
    repeat (2) @(posedge clk);
    #1;
    check_eq("single_done", 128'(done_cnt - d0), 128'(1));
    check_eq("idle_after", 128'(busy_o), 128'(0));
  endtask

  logic [127:0] pt, ct, pt2, ct2;
  int c0, d0, guard;

  initial begin
    n_chk = 0; n_pass = 0;
    issue_cnt = 0; issue_base = 0; lat_fixed = 1;
    rst_i = 1'b1; start_i = 1'b0; inj_valid = 1'b0; data_i = '0;
    build_sbox();
    expand_key(128'h000102030405060708090a0b0c0d0e0f);
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", 128'(busy_o), 128'(0));
    check_eq("rst_rnd_valid", 128'(rnd_valid_o), 128'(0));
    check_eq("rst_rnd_last", 128'(rnd_last_o), 128'(0));
    check_eq("rst_done", 128'(done_o), 128'(0));
    check_eq("rst_data_valid", 128'(data_valid_o), 128'(0));
    check_eq("rst_proto", 128'(proto_err_o), 128'(0));
    check_eq("rst_data_o", data_o, 128'h0);
    check_eq("rst_rnd_data", rnd_data_o, 128'h0);
    check_eq("rst_rnd_key", rnd_key_o, rk[0]);
    rst_i = 1'b0;
    @(posedge clk); #1;

    // FIPS-197 C.1 with L=1 and L=3
    run_block(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff, 1, 0);
    run_block(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff, 3, 0);

    // random keys/plaintexts, random per-round latency
    for (int i = 0; i < 4; i++) begin
      expand_key(rand128());
      pt = rand128();
      run_block(aes_enc(pt), pt, 0, 0);
    end

    // start pulses while busy are ignored
    pt = rand128();
    run_block(aes_enc(pt), pt, 1, 1);

    // back-to-back with start held high
    lat_fixed = 1;
    pt = rand128(); ct = aes_enc(pt);
    pt2 = rand128(); ct2 = aes_enc(pt2);
    issue_base = issue_cnt;
    d0 = done_cnt;
    data_i = ct;
    start_i = 1'b1;
    c0 = cyc;
    while (cyc < c0 + 23) begin
      if (cyc == c0 + 3) data_i = ct2;
      @(posedge clk); #1;
    end
    check_eq("b2b_idle", 128'(busy_o), 128'(0));
    check_eq("b2b_valid1", 128'(data_valid_o), 128'(1));
    check_eq("b2b_pt1", data_o, pt);
    check_eq("b2b_done1", 128'(done_cnt - d0), 128'(1));
    @(posedge clk); #1;
    start_i = 1'b0;
    check_eq("b2b_init2", 128'(busy_o), 128'(1));
    check_eq("b2b_valid_drop", 128'(data_valid_o), 128'(0));
    guard = 0;
    while (done_cnt - d0 < 2 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    check_eq("b2b_done2_cycle", 128'(done_cyc), 128'(c0 + 45));
    check_eq("b2b_pt2", data_o, pt2);
    check_eq("b2b_issues", 128'(issue_cnt - issue_base), 128'(20));

    // reset during WAIT of round 4 (sixth transaction), response lands in reset
    expand_key(128'h000102030405060708090a0b0c0d0e0f);
    lat_fixed = 3;
    data_i = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    issue_base = issue_cnt;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    guard = 0;
    while (issue_cnt - issue_base < 6 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    check_eq("reach_round4", 128'(issue_cnt - issue_base), 128'(6));
    #2;
    rst_i = 1'b1;
    #1;
    check_eq("arst_busy", 128'(busy_o), 128'(0));
    check_eq("arst_data_o", data_o, 128'h0);
    check_eq("arst_rnd_data", rnd_data_o, 128'h0);
    check_eq("arst_rnd_key", rnd_key_o, rk[0]);
    check_eq("arst_rnd_valid", 128'(rnd_valid_o), 128'(0));
    check_eq("arst_data_valid", 128'(data_valid_o), 128'(0));
    repeat (6) @(posedge clk);
    #1;
    rst_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("arst_no_proto", 128'(proto_err_o), 128'(0));
    run_block(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff, 1, 0);

    // stray response in IDLE: sticky error, state unaffected
    check_eq("proto_clear", 128'(proto_err_o), 128'(0));
    inj_valid = 1'b1;
    @(posedge clk); #1;
    inj_valid = 1'b0;
    check_eq("proto_idle", 128'(proto_err_o), 128'(1));
    check_eq("proto_idle_busy", 128'(busy_o), 128'(0));
    repeat (3) @(posedge clk);
    #1;
    check_eq("proto_sticky", 128'(proto_err_o), 128'(1));
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(posedge clk); #1;
    check_eq("proto_reset", 128'(proto_err_o), 128'(0));

    // response in the same cycle as the request
    pt = rand128();
    run_block(aes_enc(pt), pt, 2, 2);
    check_eq("proto_issue", 128'(proto_err_o), 128'(1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/aes_inv_round_sequencer.md
# aes_inv_round_sequencer

AES-128 decryption round sequencer: the inverse-cipher counterpart of the encryption round orchestrator. It takes one ciphertext block and the 11 expanded round keys, applies the initial AddRoundKey (K10), and drives an external inverse-round unit through 10 request/response transactions using keys K9..K0. It then returns the plaintext. It sits between the AHB slave register file (ciphertext and keys in, plaintext out) and the inverse round datapath (InvShiftRows, InvSubBytes, AddRoundKey, optional InvMixColumns).

## Interface
- WIDTH, 128, block and round-key width
- NR, 10, number of cipher rounds
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- start_i  in  1  start request, sampled only in IDLE
- data_i  in  WIDTH  ciphertext, sampled in INIT
- key_0_i .. key_10_i  in  WIDTH each  round keys; key_0_i is the cipher key; all held stable while busy_o=1
- rnd_data_o  out  WIDTH  state sent to the inverse round unit
- rnd_key_o  out  WIDTH  round key for the current transaction
- rnd_valid_o  out  1  one-cycle request strobe
- rnd_last_o  out  1  final round; round unit skips InvMixColumns; qualified by rnd_valid_o
- rnd_data_i  in  WIDTH  round unit result
- rnd_valid_i  in  1  one-cycle response strobe
- data_o  out  WIDTH  plaintext, registered
- data_valid_o  out  1  high from DONE until the next accepted start
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle completion pulse
- proto_err_o  out  1  sticky protocol error; cleared only by reset

## Operation
- States: IDLE, INIT, ISSUE, WAIT, DONE.
- IDLE:
  - If start_i=1, go to INIT and clear data_valid_o.
  - Otherwise stay in IDLE.
- INIT:
  - state_q <= data_i ^ key_10_i.
  - round_q <= NR-1 (9).
  - Go to ISSUE.
- ISSUE (exactly one cycle):
  - rnd_valid_o=1, rnd_data_o=state_q, rnd_key_o=key_<round_q>_i, rnd_last_o=(round_q==0).
  - Go to WAIT.
- WAIT:
  - On rnd_valid_i=1: state_q <= rnd_data_i.
  - If round_q==0, go to DONE.
  - Otherwise round_q <= round_q-1 and go to ISSUE.
- DONE:
  - data_o <= state_q, data_valid_o <= 1, done_o=1.
  - Go to IDLE.
- Round counter is 4 bits and counts down 9..0. It never wraps: decrement happens only when round_q != 0.
- Key order: K10 (INIT XOR), then K9, K8, .. K0. rnd_last_o=1 only with K0.
- rnd_data_o and rnd_key_o are driven from registers/mux at all times; they are meaningful only when rnd_valid_o=1.
- start_i outside IDLE is ignored.
- start_i held high re-triggers on the cycle after DONE returns to IDLE.
- rnd_valid_i in any state other than WAIT is ignored and sets proto_err_o.
- rnd_valid_i in the same cycle as rnd_valid_o (ISSUE) is also an error: the response latency must be at least 1.
- Reset mid-operation:
  - Return to IDLE immediately.
  - Any in-flight round-unit response is ignored.
  - Later stray responses set proto_err_o only after reset deassertion.

## Timing
- Reset values:
  - state IDLE, round_q 0, state_q 0.
  - data_o 0, rnd_data_o 0, rnd_key_o = key_0_i (mux of round_q=0).
  - rnd_valid_o 0, rnd_last_o 0, data_valid_o 0, busy_o 0, done_o 0, proto_err_o 0.
- Let start be accepted at cycle 0 and round-unit latency L≥1 (response L cycles after the ISSUE cycle).
  - INIT at cycle 1.
  - ISSUE k (k=0..9) at cycle 2+k(1+L).
  - DONE/done_o at cycle 12+10L. For L=1 that is cycle 22.
- data_o and data_valid_o update on the DONE clock edge and are visible from cycle 13+10L.
- busy_o is high from cycle 1 through the DONE cycle inclusive.
- Minimum start-to-start spacing is 13+10L cycles.

## Structure
- Shared package aes_pkg:
  - AES_WIDTH=128, AES_NR=10.
  - Sequencer state enum (IDLE/INIT/ISSUE/WAIT/DONE).
  - Round-counter width constant.
- Sub-module aes_rkey_sel: combinational 11:1 round-key mux indexed by round_q. It is reused by the encryption side.
- The inverse round datapath is external and is not part of this block.

## Test plan
- FIPS-197 C.1 decryption, L=1:
  - Stimulus: ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, key 000102030405060708090a0b0c0d0e0f expanded, behavioural inverse-round responder.
  - Required response: data_o=00112233445566778899aabbccddeeff, done_o pulse at cycle 22, exactly 10 rnd_valid_o pulses.
  - Key order: first rnd_key_o=K9, last rnd_key_o=K0 with rnd_last_o=1.
- Variable latency:
  - Stimulus: responder delays L=1, 3, then random 1..8 per round.
  - Required response: correct plaintext, and done_o at 12+10L for fixed L.
- start_i during busy:
  - Stimulus: pulse start_i at cycles 5 and 15.
  - Required response: ignored, single done_o, no extra rnd_valid_o.
- Protocol error:
  - Stimulus: rnd_valid_i asserted in IDLE, and again in the ISSUE cycle.
  - Required response: proto_err_o=1 and stays 1; state unaffected.
- Reset mid-operation:
  - Stimulus: assert rst_i during WAIT of round 4.
  - Required response: all outputs return to reset values asynchronously.
  - Recovery: a following decrypt of the C.1 vector completes correctly.
- Back-to-back:
  - Stimulus: start_i held high across two blocks.
  - Required response: second INIT on the cycle after returning to IDLE.
  - data_valid_o drops at the second accept; both plaintexts are correct.
